// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_pkg
// Brief    : Shared types and default screen constants for the obstacle field.
// Revision : 1.0 - initial release
// ============================================================================
package obstacle_pkg;

    // Top-level play state of the obstacle field.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } obs_state_t;

    // Default screen geometry (pixels).
    localparam int c_SPAWN_X = 680;
    localparam int c_SPACING = 213;
    localparam int c_BIRD_X  = 100;
    localparam int c_Y_MIN   = 125;
    localparam int c_Y_MAX   = 300;
    localparam int c_X_W     = 10;

    // One obstacle slot at the default coordinate width.
    typedef struct packed {
        logic             en;
        logic [c_X_W-1:0] x;
        logic [c_X_W-1:0] y;
    } obs_slot_t;

endpackage
`default_nettype wire

// File: rtl/obstacle_field_gap_picker.sv
`default_nettype none
// ============================================================================
// Module   : gap_picker
// Brief    : Scales an 8-bit random value into a gap centre in [Y_MIN, Y_MAX).
// Revision : 1.0 - initial release
// ============================================================================
module gap_picker
    import obstacle_pkg::*;
#(
    parameter int Y_MIN = c_Y_MIN,
    parameter int Y_MAX = c_Y_MAX,
    parameter int X_W   = c_X_W
) (
    input  logic [7:0]     i_rand,
    output logic [X_W-1:0] o_y
);

    localparam int c_range  = Y_MAX - Y_MIN;
    localparam int c_prod_w = X_W + 8;

    logic [c_prod_w-1:0] w_prod;

    // rand * range / 256 keeps the result strictly below Y_MAX.
    assign w_prod = c_prod_w'(i_rand) * c_prod_w'(c_range);
    assign o_y    = X_W'(Y_MIN) + X_W'(w_prod >> 8);

endmodule
`default_nettype wire

// File: rtl/obstacle_field.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_field
// Brief    : N_OBS scrolling pipe slots with spawn, retire and crossing score.
//            Optional build macro OBS_DIFFICULTY_EN adds score-driven speed-up.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int N_OBS   = 3,
    parameter int X_W     = c_X_W,
    parameter int SPAWN_X = c_SPAWN_X,
    parameter int SPACING = c_SPACING,
    parameter int BIRD_X  = c_BIRD_X,
    parameter int Y_MIN   = c_Y_MIN,
    parameter int Y_MAX   = c_Y_MAX,
    parameter int SCORE_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   tick,
    input  logic [2:0]             speed,
    input  logic [7:0]             rand_byte,
    output logic [N_OBS-1:0]       obs_en,
    output logic [N_OBS*X_W-1:0]   obs_x,
    output logic [N_OBS*X_W-1:0]   obs_y,
    output logic [SCORE_W-1:0]     score,
    output logic                   score_pulse
);

    localparam int                 c_sp_w      = $clog2(N_OBS);
    localparam int                 c_cnt_w     = $clog2(N_OBS + 1);
    localparam logic [c_sp_w-1:0]  c_sp_last   = c_sp_w'(N_OBS - 1);
    localparam logic [X_W-1:0]     c_spawn_x   = X_W'(SPAWN_X);
    localparam logic [X_W-1:0]     c_spawn_thr = X_W'(SPAWN_X - SPACING);
    localparam logic [X_W-1:0]     c_bird_x    = X_W'(BIRD_X);
    localparam logic [X_W-1:0]     c_y_min     = X_W'(Y_MIN);
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    obs_state_t          r_state, w_state_nxt;
    logic                w_step;
    logic                w_spawn;
    logic [N_OBS-1:0]    r_en, w_en_nxt;
    logic [X_W-1:0]      r_x [N_OBS];
    logic [X_W-1:0]      w_x_nxt [N_OBS];
    logic [X_W-1:0]      r_y [N_OBS];
    logic [X_W-1:0]      w_y_nxt [N_OBS];
    logic [c_sp_w-1:0]   r_sp, w_sp_nxt, w_sp_prev;
    logic [SCORE_W-1:0]  r_score, w_score_nxt;
    logic [SCORE_W:0]    w_score_sum;
    logic                r_pulse, w_pulse_nxt;
    logic [c_cnt_w-1:0]  w_cross_cnt;
    logic [2:0]          w_eff_speed;
    logic [X_W-1:0]      w_eff_x;
    logic [X_W-1:0]      w_gap_y;

    // Single shared gap generator feeds whichever slot spawns.
    gap_picker #(
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX),
        .X_W   (X_W)
    ) u_gap_picker (
        .i_rand (rand_byte),
        .o_y    (w_gap_y)
    );

`ifdef OBS_DIFFICULTY_EN
    logic [SCORE_W-1:0] w_boost_sum;
    // Speed rises by one every 16 points, capped at 7.
    assign w_boost_sum = SCORE_W'(speed) + SCORE_W'(r_score[SCORE_W-1:4]);
    assign w_eff_speed = (w_boost_sum > SCORE_W'(7)) ? 3'd7 : w_boost_sum[2:0];
`else
    assign w_eff_speed = speed;
`endif
    assign w_eff_x = X_W'(w_eff_speed);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state: a running tick starts play, run low freezes it.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (tick && run) w_state_nxt = ST_RUN;
                ST_RUN:    if (!run)        w_state_nxt = ST_FREEZE;
                ST_FREEZE: if (run)         w_state_nxt = ST_RUN;
                default:                    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM output: a frame step happens only on a live tick outside FREEZE.
    always_comb begin
        w_step = 1'b0;
        if (!clear && tick && run && (r_state != ST_FREEZE)) w_step = 1'b1;
    end

    assign w_sp_prev = (r_sp == '0) ? c_sp_last : r_sp - 1'b1;
    assign w_spawn   = !r_en[r_sp] && (!(|r_en) || (r_x[w_sp_prev] <= c_spawn_thr));

    // Slot, spawn pointer and score next-state for one frame step.
    always_comb begin
        w_en_nxt    = r_en;
        w_sp_nxt    = r_sp;
        w_cross_cnt = '0;
        for (int i = 0; i < N_OBS; i++) begin
            w_x_nxt[i] = r_x[i];
            w_y_nxt[i] = r_y[i];
            if (w_step) begin
                if (w_spawn && (i == int'(r_sp))) begin
                    w_en_nxt[i] = 1'b1;
                    w_x_nxt[i]  = c_spawn_x;
                    w_y_nxt[i]  = w_gap_y;
                end else if (r_en[i]) begin
                    if (r_x[i] < w_eff_x) begin
                        w_en_nxt[i] = 1'b0;
                        w_x_nxt[i]  = c_spawn_x;
                        w_y_nxt[i]  = c_y_min;
                    end else begin
                        w_x_nxt[i] = r_x[i] - w_eff_x;
                        if ((r_x[i] > c_bird_x) && (w_x_nxt[i] <= c_bird_x))
                            w_cross_cnt = w_cross_cnt + c_cnt_w'(1);
                    end
                end
            end
        end
        if (w_step && w_spawn)
            w_sp_nxt = (r_sp == c_sp_last) ? '0 : r_sp + 1'b1;

        w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_cross_cnt);
        w_score_nxt = (w_score_sum > {1'b0, c_score_max}) ? c_score_max
                                                           : w_score_sum[SCORE_W-1:0];
        w_pulse_nxt = w_step && (w_cross_cnt != '0);

        if (clear) begin
            w_en_nxt    = '0;
            w_sp_nxt    = '0;
            w_score_nxt = '0;
            w_pulse_nxt = 1'b0;
            for (int i = 0; i < N_OBS; i++) begin
                w_x_nxt[i] = c_spawn_x;
                w_y_nxt[i] = c_y_min;
            end
        end
    end

    // Field state registers; clear is folded into the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en    <= '0;
            r_sp    <= '0;
            r_score <= '0;
            r_pulse <= 1'b0;
            for (int i = 0; i < N_OBS; i++) begin
                r_x[i] <= c_spawn_x;
                r_y[i] <= c_y_min;
            end
        end else begin
            r_en    <= w_en_nxt;
            r_sp    <= w_sp_nxt;
            r_score <= w_score_nxt;
            r_pulse <= w_pulse_nxt;
            for (int i = 0; i < N_OBS; i++) begin
                r_x[i] <= w_x_nxt[i];
                r_y[i] <= w_y_nxt[i];
            end
        end
    end

    assign obs_en      = r_en;
    assign score       = r_score;
    assign score_pulse = r_pulse;

    generate
        for (genvar g = 0; g < N_OBS; g++) begin : g_pack
            assign obs_x[g*X_W +: X_W] = r_x[g];
            assign obs_y[g*X_W +: X_W] = r_y[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_obstacle_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_field
// Brief    : Randomised self-checking bench for obstacle_field against a
//            behavioural model of the pipe field.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_field;
    import obstacle_pkg::*;

    localparam int N     = 3;
    localparam int XW    = 10;
    localparam int SW    = 7;
    localparam int SMAX  = 127;

    logic           clk = 1'b0;
    logic           reset, clear, run, tick;
    logic [2:0]     speed;
    logic [7:0]     rand_byte;
    logic [N-1:0]   obs_en;
    logic [N*XW-1:0] obs_x, obs_y;
    logic [SW-1:0]  score;
    logic           score_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    obs_slot_t m_slot [N];
    int        m_score;
    int        m_sp;
    bit        m_pulse;
    bit        m_started;
    bit        m_frozen;

    obstacle_field #(
        .N_OBS(N), .X_W(XW), .SPAWN_X(680), .SPACING(213), .BIRD_X(100),
        .Y_MIN(125), .Y_MAX(300), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .run(run), .tick(tick),
        .speed(speed), .rand_byte(rand_byte), .obs_en(obs_en), .obs_x(obs_x),
        .obs_y(obs_y), .score(score), .score_pulse(score_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_slot[i].en = 1'b0;
            m_slot[i].x  = 10'd680;
            m_slot[i].y  = 10'd125;
        end
        m_score   = 0;
        m_sp      = 0;
        m_pulse   = 1'b0;
        m_started = 1'b0;
        m_frozen  = 1'b0;
    endtask

    // One clock of the field behaviour, written from the game rules.
    task automatic model_step(input bit clr, input bit rn, input bit tk, input int spd, input int rnd);
        int  eff, prev, k, ox, nx;
        bit  any, step;
        int  spawn_idx;
        if (clr) begin
            model_reset();
            return;
        end
        step    = tk && rn && !m_frozen;
        m_pulse = 1'b0;
        if (tk && rn) m_started = 1'b1;
        if (step) begin
`ifdef OBS_DIFFICULTY_EN
            eff = spd + m_score / 16;
            if (eff > 7) eff = 7;
`else
            eff = spd;
`endif
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= m_slot[i].en;
            prev      = (m_sp + N - 1) % N;
            spawn_idx = -1;
            if (!m_slot[m_sp].en && (!any || int'(m_slot[prev].x) <= 680 - 213))
                spawn_idx = m_sp;
            k = 0;
            for (int i = 0; i < N; i++) begin
                ox = int'(m_slot[i].x);
                if (i == spawn_idx) begin
                    m_slot[i].en = 1'b1;
                    m_slot[i].x  = 10'd680;
                    m_slot[i].y  = 10'(125 + (rnd * 175) / 256);
                end else if (m_slot[i].en) begin
                    if (ox < eff) begin
                        m_slot[i].en = 1'b0;
                        m_slot[i].x  = 10'd680;
                        m_slot[i].y  = 10'd125;
                    end else begin
                        nx = ox - eff;
                        if (ox > 100 && nx <= 100) k++;
                        m_slot[i].x = 10'(nx);
                    end
                end
            end
            if (spawn_idx >= 0) m_sp = (m_sp + 1) % N;
            m_score = (m_score + k > SMAX) ? SMAX : m_score + k;
            m_pulse = (k > 0);
        end
        m_frozen = m_started && !rn;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] exp_en;
        for (int i = 0; i < N; i++) exp_en[i] = m_slot[i].en;
        check_val({tag, "_en"}, 32'(obs_en), 32'(exp_en));
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("%s_x%0d", tag, i), 32'(obs_x[i*XW +: XW]), 32'(m_slot[i].x));
            check_val($sformatf("%s_y%0d", tag, i), 32'(obs_y[i*XW +: XW]), 32'(m_slot[i].y));
        end
        check_val({tag, "_score"}, 32'(score), 32'(m_score));
        check_val({tag, "_pulse"}, 32'(score_pulse), 32'(m_pulse));
    endtask

    task automatic cycle(input bit clr, input bit rn, input bit tk, input int spd, input int rnd,
                         input string tag);
        @(negedge clk);
        clear     = clr;
        run       = rn;
        tick      = tk;
        speed     = 3'(spd);
        rand_byte = 8'(rnd);
        model_step(clr, rn, tk, spd, rnd);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic random_phase(input int cycles, input int clr_mod, input string tag);
        bit rn, tk, clr;
        int spd;
        for (int c = 0; c < cycles; c++) begin
            clr = ($urandom % clr_mod) == 0;
            rn  = ($urandom % 40) != 0;
            tk  = ($urandom % 3) != 0;
            if (m_frozen && rn) tk = 1'b0;
            spd = (($urandom % 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(3, 7));
            cycle(clr, rn, tk, spd, int'($urandom % 256), tag);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; run = 1'b0; tick = 1'b0;
        speed = 3'd0; rand_byte = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        reset = 1'b0;

        // First tick spawns slot 0 with the minimum gap.
        cycle(1'b0, 1'b1, 1'b1, 1, 0, "spawn0");
        check_val("spawn0_en_c", 32'(obs_en), 32'd1);
        check_val("spawn0_x_c", 32'(obs_x[0 +: XW]), 32'd680);
        check_val("gap_min", 32'(obs_y[0 +: XW]), 32'd125);

        // Speed 1 scroll until slot 1 spawns with the maximum gap.
        for (int t = 0; t < 230; t++) begin
            cycle(1'b0, 1'b1, 1'b1, 1, 255, "scroll");
            cycle(1'b0, 1'b1, 1'b0, 1, 255, "scroll");
        end
        check_val("spawn1_en_c", 32'(obs_en[1]), 32'd1);
        check_val("gap_max", 32'(obs_y[XW +: XW]), 32'd299);

        // Freeze for 50 frames of ticks, then resume without a tick.
        cycle(1'b0, 1'b0, 1'b0, 5, 17, "frz_in");
        for (int t = 0; t < 50; t++) cycle(1'b0, 1'b0, 1'b1, 5, int'($urandom % 256), "frz");
        cycle(1'b0, 1'b1, 1'b0, 5, 17, "frz_out");

        // Fast scroll long enough to reach score saturation.
        for (int t = 0; t < 7000; t++) cycle(1'b0, 1'b1, 1'b1, 7, int'($urandom % 256), "sat");
        check_val("score_sat", 32'(score), 32'(SMAX));

        // Asynchronous reset mid-frame.
        @(negedge clk);
        #2;
        reset = 1'b1; tick = 1'b0; run = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_val("async_rst_en_c", 32'(obs_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        random_phase(5000, 2500, "rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
